// File: rtl/serial_link_flit_splitter.sv
// serial_link_flit_splitter: TX data-link stage that accepts one wide protocol
// payload per handshake and emits it LSB-first as narrow flits, flagging the
// final flit of each payload. Back-to-back payloads run with no bubble.
// Optional macro SERIAL_LINK_SPLIT_SHORT_EN: trailing all-zero flits of a
// payload are dropped and the last flag asserts on the highest nonzero flit.
module serial_link_flit_splitter #(
  parameter int unsigned PayloadWidth = 128,
  parameter int unsigned FlitWidth    = 32,
  localparam int unsigned NumFlits    = (PayloadWidth + FlitWidth - 1) / FlitWidth,
  localparam int unsigned IdxWidth    = (NumFlits > 1) ? $clog2(NumFlits) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    payload_valid_i,
  output logic                    payload_ready_o,
  input  logic [PayloadWidth-1:0] payload_data_i,
  output logic                    flit_valid_o,
  input  logic                    flit_ready_i,
  output logic [FlitWidth-1:0]    flit_data_o,
  output logic                    flit_last_o,
  output logic [IdxWidth-1:0]     flit_idx_o,
  output logic                    busy_o
);

  localparam int unsigned PadWidth = NumFlits * FlitWidth;
  localparam logic [IdxWidth-1:0] LastIdxFull = IdxWidth'(NumFlits - 1);

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PadWidth-1:0]   pad_q, pad_d;
  logic [IdxWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   last_idx_q, last_idx_d;
  logic                  last_q, last_d;

  logic [PadWidth-1:0]   pad_in;
  logic [PadWidth-1:0]   pad_shift;
  logic [IdxWidth-1:0]   new_last_idx;
  logic                  flit_fire;
  logic                  last_fire;
  logic                  accept;

  assign pad_in = PadWidth'(payload_data_i);

  // Payload register shifts down one flit per handshake; the low flit is on the wire.
  if (NumFlits > 1) begin : g_shift
    assign pad_shift = {FlitWidth'(0), pad_q[PadWidth-1:FlitWidth]};
  end else begin : g_noshift
    assign pad_shift = '0;
  end

`ifdef SERIAL_LINK_SPLIT_SHORT_EN
  // Highest flit index of the incoming payload that carries a nonzero bit.
  always_comb begin
    new_last_idx = '0;
    for (int unsigned i = 0; i < NumFlits; i++) begin
      if (|pad_in[i*FlitWidth +: FlitWidth]) begin
        new_last_idx = IdxWidth'(i);
      end
    end
  end
`else
  assign new_last_idx = LastIdxFull;
`endif

  // Handshake decode; ready reopens in the cycle the last flit is taken.
  assign flit_fire       = (state_q == StSend) && flit_ready_i;
  assign last_fire       = flit_fire && last_q;
  assign payload_ready_o = (state_q == StIdle) || last_fire;
  assign accept          = payload_valid_i && payload_ready_o;

  // Next-state: capture has priority, so a last-flit handshake can reload directly.
  always_comb begin
    state_d    = state_q;
    pad_d      = pad_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    last_d     = last_q;
    if (accept) begin
      state_d    = StSend;
      pad_d      = pad_in;
      cnt_d      = '0;
      last_idx_d = new_last_idx;
      last_d     = (new_last_idx == '0);
    end else if (last_fire) begin
      state_d = StIdle;
      pad_d   = '0;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else if (flit_fire) begin
      pad_d  = pad_shift;
      cnt_d  = cnt_q + IdxWidth'(1);
      last_d = ((cnt_q + IdxWidth'(1)) == last_idx_q);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pad_q      <= '0;
      cnt_q      <= '0;
      last_idx_q <= LastIdxFull;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pad_q      <= pad_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      last_q     <= last_d;
    end
  end

  assign flit_valid_o = (state_q == StSend);
  assign busy_o       = (state_q == StSend);
  assign flit_data_o  = pad_q[FlitWidth-1:0];
  assign flit_last_o  = last_q;
  assign flit_idx_o   = cnt_q;

endmodule

// File: tb/tb_serial_link_flit_splitter.sv
// Directed bench for serial_link_flit_splitter at PayloadWidth=80, FlitWidth=32.
module tb_serial_link_flit_splitter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        payload_valid_i = 1'b0;
  logic        payload_ready_o;
  logic [79:0] payload_data_i = '0;
  logic        flit_valid_o;
  logic        flit_ready_i = 1'b1;
  logic [31:0] flit_data_o;
  logic        flit_last_o;
  logic [1:0]  flit_idx_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  serial_link_flit_splitter #(.PayloadWidth(80), .FlitWidth(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .payload_valid_i (payload_valid_i),
    .payload_ready_o (payload_ready_o),
    .payload_data_i  (payload_data_i),
    .flit_valid_o    (flit_valid_o),
    .flit_ready_i    (flit_ready_i),
    .flit_data_o     (flit_data_o),
    .flit_last_o     (flit_last_o),
    .flit_idx_o      (flit_idx_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [79:0] data;
    logic        fr;
    logic        chk;
    logic        prdy;
    logic        fvld;
    logic [31:0] fdata;
    logic        last;
    logic [1:0]  idx;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic add_raw(input logic rst, input logic vld, input logic [79:0] data,
                         input logic fr, input logic chk, input logic prdy, input logic fvld,
                         input logic [31:0] fdata, input logic last, input logic [1:0] idx,
                         input logic busy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data; v.fr = fr; v.chk = chk;
    v.prdy = prdy; v.fvld = fvld; v.fdata = fdata; v.last = last; v.idx = idx; v.busy = busy;
    vq.push_back(v);
  endtask

  // Cycle where the block is expected idle and ready.
  task automatic add_idle(input logic rst, input logic vld, input logic [79:0] data);
    add_raw(rst, vld, data, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
  endtask

  // Cycle where a flit is expected on the wire.
  task automatic add_flit(input logic rst, input logic vld, input logic [79:0] data,
                          input logic fr, input logic [31:0] fdata, input logic [1:0] idx,
                          input logic last, input logic prdy);
    add_raw(rst, vld, data, fr, 1'b1, prdy, 1'b1, fdata, last, idx, 1'b1);
  endtask

  // Accept from idle, then drain n flits with ready held high.
  task automatic add_payload(input logic [79:0] p, input logic [31:0] f0, input logic [31:0] f1,
                             input logic [31:0] f2, input int n);
    logic [31:0] f [3];
    f[0] = f0; f[1] = f1; f[2] = f2;
    add_idle(1'b0, 1'b1, p);
    for (int k = 0; k < n; k++) begin
      add_flit(1'b0, 1'b0, 80'h0, 1'b1, f[k], 2'(k), k == n - 1, k == n - 1);
    end
  endtask

  initial begin
    logic [79:0] pa;
    logic [79:0] pb;
    logic [79:0] pc;
    logic [31:0] exp_f [3];
    int          nflit;
    int          budget;

    pa = 80'h1234_89ABCDEF_01234567;
    pb = 80'hBEEF_CAFEBABE_DEADBEEF;
    pc = 80'hA5A5_11112222_33334444;

    // Reset, then single payload with ready high.
    add_raw(1'b1, 1'b0, 80'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
    add_idle(1'b0, 1'b0, 80'h0);
    add_payload(pa, 32'h01234567, 32'h89ABCDEF, 32'h00001234, 3);
    add_idle(1'b0, 1'b0, 80'h0);

    // Back-to-back: valid held high, B accepted in A's last handshake.
    add_idle(1'b0, 1'b1, pa);
    add_flit(1'b0, 1'b1, pb, 1'b1, 32'h01234567, 2'd0, 1'b0, 1'b0);
    add_flit(1'b0, 1'b1, pb, 1'b1, 32'h89ABCDEF, 2'd1, 1'b0, 1'b0);
    add_flit(1'b0, 1'b1, pb, 1'b1, 32'h00001234, 2'd2, 1'b1, 1'b1);
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0);
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'hCAFEBABE, 2'd1, 1'b0, 1'b0);
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'h0000BEEF, 2'd2, 1'b1, 1'b1);
    add_idle(1'b0, 1'b0, 80'h0);

    // Backpressure on idx1 for 4 cycles; a pending payload must not be taken.
    add_idle(1'b0, 1'b1, pa);
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'h01234567, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      add_flit(1'b0, 1'b1, pb, 1'b0, 32'h89ABCDEF, 2'd1, 1'b0, 1'b0);
    end
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'h89ABCDEF, 2'd1, 1'b0, 1'b0);
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'h00001234, 2'd2, 1'b1, 1'b1);
    add_idle(1'b0, 1'b0, 80'h0);

    // Reset asserted during idx1, then a new payload restarts at idx0.
    add_idle(1'b0, 1'b1, pa);
    add_flit(1'b0, 1'b0, 80'h0, 1'b1, 32'h01234567, 2'd0, 1'b0, 1'b0);
    add_flit(1'b1, 1'b0, 80'h0, 1'b1, 32'h89ABCDEF, 2'd1, 1'b0, 1'b0);
    add_payload(pb, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0000BEEF, 3);
    add_idle(1'b0, 1'b0, 80'h0);

    // Payloads with trailing zero flits.
`ifdef SERIAL_LINK_SPLIT_SHORT_EN
    add_payload(80'hFF, 32'h000000FF, 32'h0, 32'h0, 1);
    add_payload(80'h1_00000000, 32'h0, 32'h00000001, 32'h0, 2);
    add_payload(80'h0, 32'h0, 32'h0, 32'h0, 1);
`else
    add_payload(80'hFF, 32'h000000FF, 32'h0, 32'h0, 3);
    add_payload(80'h1_00000000, 32'h0, 32'h00000001, 32'h0, 3);
    add_payload(80'h0, 32'h0, 32'h0, 32'h0, 3);
`endif
    add_idle(1'b0, 1'b0, 80'h0);

    // Apply the table: drive on the falling edge, check 1 time unit later.
    foreach (vq[n]) begin
      @(negedge clk_i);
      rst_i           = vq[n].rst;
      payload_valid_i = vq[n].vld;
      payload_data_i  = vq[n].data;
      flit_ready_i    = vq[n].fr;
      #1;
      if (vq[n].chk) begin
        total++;
        if (payload_ready_o !== vq[n].prdy || flit_valid_o !== vq[n].fvld ||
            flit_data_o !== vq[n].fdata || flit_last_o !== vq[n].last ||
            flit_idx_o !== vq[n].idx || busy_o !== vq[n].busy) begin
          bad++;
          $display("FAIL vec%0d: got rdy=%b vld=%b data=%h last=%b idx=%0d busy=%b, expected rdy=%b vld=%b data=%h last=%b idx=%0d busy=%b",
                   n, payload_ready_o, flit_valid_o, flit_data_o, flit_last_o, flit_idx_o, busy_o,
                   vq[n].prdy, vq[n].fvld, vq[n].fdata, vq[n].last, vq[n].idx, vq[n].busy);
        end
      end
    end

    // Hand sequence: random flit_ready, bounded wait for all three flits in order.
    exp_f[0] = 32'h33334444; exp_f[1] = 32'h11112222; exp_f[2] = 32'h0000A5A5;
    @(negedge clk_i);
    rst_i = 1'b0; payload_valid_i = 1'b1; payload_data_i = pc; flit_ready_i = 1'b0;
    #1;
    total++;
    if (payload_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rand_accept: got rdy=%b, expected 1", payload_ready_o);
    end
    nflit  = 0;
    budget = 0;
    while (nflit < 3 && budget < 60) begin
      @(negedge clk_i);
      payload_valid_i = 1'b0;
      payload_data_i  = '0;
      flit_ready_i    = 1'($urandom_range(0, 1));
      #1;
      budget++;
      if (flit_valid_o && flit_ready_i) begin
        total++;
        if (flit_data_o !== exp_f[nflit] || flit_idx_o !== 2'(nflit) ||
            flit_last_o !== (nflit == 2)) begin
          bad++;
          $display("FAIL rand_flit%0d: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                   nflit, flit_data_o, flit_idx_o, flit_last_o, exp_f[nflit], nflit, nflit == 2);
        end
        nflit++;
      end
    end
    if (nflit < 3) begin
      total++;
      bad++;
      $display("FAIL rand_timeout: got %0d flits, expected 3", nflit);
    end
    @(negedge clk_i);
    flit_ready_i = 1'b1;
    #1;
    total++;
    if (flit_valid_o !== 1'b0 || payload_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rand_idle: got vld=%b rdy=%b, expected vld=0 rdy=1", flit_valid_o, payload_ready_o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
